// File: rtl/alu_control_mc.sv
// ALU control decoder with an iterative signed/unsigned multiplier.
// The multiplier fills HI/LO and stalls the pipeline while it runs.
module alu_control_mc #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEP_BITS  = 1,
   parameter int unsigned CTRL_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [1:0]            ALUOp_i,
   input  logic [5:0]            funct_i,
   input  logic [DATA_WIDTH-1:0] rs_data_i,
   input  logic [DATA_WIDTH-1:0] rt_data_i,
   output logic [CTRL_WIDTH-1:0] ALUCtrl_o,
   output logic                  illegal_o,
   output logic                  stall_o,
   output logic                  mul_done_o,
   output logic [DATA_WIDTH-1:0] hi_o,
   output logic [DATA_WIDTH-1:0] lo_o
);

   localparam int unsigned Steps = DATA_WIDTH / STEP_BITS;
   localparam int unsigned CntW  = $clog2(Steps + 1);
   localparam int unsigned AccW  = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                state_q, state_d;
   logic [AccW-1:0]       acc_q, acc_d;
   logic [AccW-1:0]       mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  neg_q, neg_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;

   logic                  is_mul;
   logic                  mul_signed;
   logic [DATA_WIDTH-1:0] rs_mag;
   logic [DATA_WIDTH-1:0] rt_mag;
   logic [AccW-1:0]       partial;
   logic [AccW-1:0]       result;

   always_comb begin
      ALUCtrl_o = CTRL_WIDTH'(7);
      illegal_o = 1'b0;
      unique case (ALUOp_i)
         2'b01: ALUCtrl_o = CTRL_WIDTH'(2);
         2'b10: ALUCtrl_o = CTRL_WIDTH'(3);
         2'b11: ALUCtrl_o = CTRL_WIDTH'(1);
         2'b00: begin
            case (funct_i)
               6'b100100: ALUCtrl_o = CTRL_WIDTH'(0);
               6'b100101: ALUCtrl_o = CTRL_WIDTH'(1);
               6'b100000: ALUCtrl_o = CTRL_WIDTH'(2);
               6'b100010: ALUCtrl_o = CTRL_WIDTH'(3);
               6'b101010: ALUCtrl_o = CTRL_WIDTH'(5);
               6'b011000: ALUCtrl_o = CTRL_WIDTH'(4);
               6'b011001: ALUCtrl_o = CTRL_WIDTH'(4);
               default: begin
                  ALUCtrl_o = CTRL_WIDTH'(7);
                  illegal_o = valid_i;
               end
            endcase
         end
      endcase
   end

   assign is_mul     = valid_i && (ALUOp_i == 2'b00) &&
                       ((funct_i == 6'b011000) || (funct_i == 6'b011001));
   assign mul_signed = ~funct_i[0];

   // Most-negative operand negates to itself, which is its correct unsigned magnitude.
   assign rs_mag = (mul_signed && rs_data_i[DATA_WIDTH-1]) ? -rs_data_i : rs_data_i;
   assign rt_mag = (mul_signed && rt_data_i[DATA_WIDTH-1]) ? -rt_data_i : rt_data_i;

   always_comb begin
      partial = '0;
      for (int unsigned b = 0; b < STEP_BITS; b++) begin
         if (mplier_q[b]) partial = partial + (mcand_q << b);
      end
   end

   assign result = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         StIdle: begin
            if (is_mul) begin
               mcand_d  = AccW'(rs_mag);
               mplier_d = rt_mag;
               neg_d    = mul_signed & (rs_data_i[DATA_WIDTH-1] ^ rt_data_i[DATA_WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << STEP_BITS;
            mplier_d = mplier_q >> STEP_BITS;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(Steps - 1)) state_d = StDone;
         end
         StDone: begin
            // The retiring mult is still on the inputs here; it must not restart.
            {hi_d, lo_d} = result;
            cnt_d        = '0;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign stall_o    = ((state_q == StIdle) && is_mul) || (state_q == StBusy);
   assign mul_done_o = (state_q == StDone);
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode table, multiply latency/results,
// back-to-back issue, reset behaviour, and a STEP_BITS=4 instance.
module tb_alu_control_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] rs, rt;
   logic [2:0]  ctrl;
   logic        illegal, stall_o, mul_done_o;
   logic [31:0] hi, lo;

   logic        v4;
   logic [1:0]  op4;
   logic [5:0]  f4;
   logic [31:0] rs4, rt4;
   logic [2:0]  ctrl4;
   logic        ill4, stall4, done4;
   logic [31:0] hi4, lo4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_control_mc dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (valid),
      .ALUOp_i    (aluop),
      .funct_i    (funct),
      .rs_data_i  (rs),
      .rt_data_i  (rt),
      .ALUCtrl_o  (ctrl),
      .illegal_o  (illegal),
      .stall_o    (stall_o),
      .mul_done_o (mul_done_o),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   alu_control_mc #(.STEP_BITS(4)) dut4 (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (v4),
      .ALUOp_i    (op4),
      .funct_i    (f4),
      .rs_data_i  (rs4),
      .rt_data_i  (rt4),
      .ALUCtrl_o  (ctrl4),
      .illegal_o  (ill4),
      .stall_o    (stall4),
      .mul_done_o (done4),
      .hi_o       (hi4),
      .lo_o       (lo4)
   );

   task automatic wait_done(output int n, output logic d);
      bit fin;
      fin = 1'b0;
      n   = 0;
      d   = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
         @(negedge clk);
         if (stall_o) n++;
         else begin
            d   = mul_done_o;
            fin = 1'b1;
         end
      end
   endtask

   task automatic run_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int exp_n, input logic [31:0] eh, input logic [31:0] el,
                          input string nm);
      int   n;
      logic d;
      @(posedge clk); #1;
      valid = 1'b1; aluop = 2'b00; funct = f; rs = a; rt = b;
      wait_done(n, d);
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s stall cycles: got %0d expected %0d", nm, n, exp_n);
      end
      checks++;
      if (d !== 1'b1) begin
         errors++;
         $display("FAIL %s mul_done pulse: got %b expected 1", nm, d);
      end
      @(posedge clk); #1;
      valid = 1'b0; funct = 6'b0;
      @(negedge clk);
      checks++;
      if ({hi, lo} !== {eh, el}) begin
         errors++;
         $display("FAIL %s hi/lo: got %h_%h expected %h_%h", nm, hi, lo, eh, el);
      end
      checks++;
      if (mul_done_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL %s after done: got done=%b stall=%b expected 0 0", nm, mul_done_o,
                  stall_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; aluop = 2'b00; funct = 6'b0; rs = '0; rt = '0;
      v4 = 1'b0; op4 = 2'b00; f4 = 6'b0; rs4 = '0; rt4 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({hi, lo, stall_o, mul_done_o} !== 66'd0) begin
         errors++;
         $display("FAIL reset state: got hi=%h lo=%h stall=%b done=%b expected all 0", hi, lo,
                  stall_o, mul_done_o);
      end
   endtask

   task automatic test_decode();
      logic [1:0] op_t  [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                                 2'b10, 2'b11};
      logic [5:0] fn_t  [10] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                                 6'b000000, 6'b000000, 6'b000000, 6'b111111, 6'b000000};
      logic       v_t   [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
      logic [2:0] ec_t  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd7, 3'd2, 3'd3, 3'd1};
      logic       ei_t  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         aluop = op_t[i]; funct = fn_t[i]; valid = v_t[i];
         @(negedge clk);
         checks++;
         if (ctrl !== ec_t[i] || illegal !== ei_t[i] || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL decode[%0d]: got ctrl=%0d ill=%b stall=%b expected ctrl=%0d ill=%b stall=0",
                     i, ctrl, illegal, stall_o, ec_t[i], ei_t[i]);
         end
      end
      @(posedge clk); #1 valid = 1'b0;
   endtask

   task automatic test_mult_signed();
      run_mul(6'b011000, 32'd3, 32'hFFFF_FFFB, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult 3*-5");
   endtask

   task automatic test_multu();
      run_mul(6'b011001, 32'hFFFF_FFFF, 32'd2, 33, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
   endtask

   task automatic test_step4();
      int   n;
      logic d;
      bit   fin;
      fin = 1'b0; n = 0; d = 1'b0;
      @(posedge clk); #1;
      v4 = 1'b1; op4 = 2'b00; f4 = 6'b011001; rs4 = 32'hFFFF_FFFF; rt4 = 32'd2;
      for (int i = 0; i < 100 && !fin; i++) begin
         @(negedge clk);
         if (stall4) n++;
         else begin
            d   = done4;
            fin = 1'b1;
         end
      end
      checks++;
      if (n != 9 || d !== 1'b1) begin
         errors++;
         $display("FAIL step4 latency: got stall=%0d done=%b expected stall=9 done=1", n, d);
      end
      @(posedge clk); #1 v4 = 1'b0;
      @(negedge clk);
      checks++;
      if ({hi4, lo4} !== {32'h0000_0001, 32'hFFFF_FFFE}) begin
         errors++;
         $display("FAIL step4 hi/lo: got %h_%h expected 00000001_fffffffe", hi4, lo4);
      end
   endtask

   task automatic test_back_to_back();
      int   n;
      logic d;
      @(posedge clk); #1;
      valid = 1'b1; aluop = 2'b00; funct = 6'b011000; rs = 32'h8000_0000; rt = 32'h8000_0000;
      wait_done(n, d);
      checks++;
      if (n != 33 || d !== 1'b1) begin
         errors++;
         $display("FAIL b2b first: got stall=%0d done=%b expected 33 1", n, d);
      end
      // Next mult follows right behind the retiring one.
      @(posedge clk); #1;
      rs = 32'd7; rt = 32'd6;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1 || mul_done_o !== 1'b0 || {hi, lo} !== {32'h4000_0000, 32'h0}) begin
         errors++;
         $display("FAIL b2b restart: got stall=%b done=%b hi/lo=%h_%h expected 1 0 40000000_00000000",
                  stall_o, mul_done_o, hi, lo);
      end
      wait_done(n, d);
      checks++;
      if (n != 32 || d !== 1'b1) begin
         errors++;
         $display("FAIL b2b second: got stall=%0d done=%b expected 32 1", n, d);
      end
      @(posedge clk); #1 valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({hi, lo} !== {32'h0, 32'd42}) begin
         errors++;
         $display("FAIL b2b second hi/lo: got %h_%h expected 00000000_0000002a", hi, lo);
      end
   endtask

   task automatic test_hold_after_mult();
      logic [1:0] op_t [3] = '{2'b00, 2'b00, 2'b01};
      logic [5:0] fn_t [3] = '{6'b100000, 6'b100100, 6'b000000};
      logic [2:0] ec_t [3] = '{3'd2, 3'd0, 3'd2};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         valid = 1'b1; aluop = op_t[i]; funct = fn_t[i]; rs = 32'hDEAD_BEEF; rt = 32'h1234_5678;
         @(negedge clk);
         checks++;
         if (ctrl !== ec_t[i] || {hi, lo} !== {32'h0, 32'd42} || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got ctrl=%0d hi/lo=%h_%h stall=%b expected ctrl=%0d 0_2a 0",
                     i, ctrl, hi, lo, stall_o, ec_t[i]);
         end
      end
      @(posedge clk); #1 valid = 1'b0;
   endtask

   task automatic test_reset_in_busy();
      bit pulsed;
      run_mul(6'b011001, 32'h8000_0001, 32'd2, 33, 32'h1, 32'h2, "multu pre-reset");
      @(posedge clk); #1;
      valid = 1'b1; aluop = 2'b00; funct = 6'b011000; rs = 32'd3; rt = 32'd5;
      repeat (10) @(posedge clk);
      #1; rst = 1'b1; valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL busy before reset: got stall=%b expected 1", stall_o);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0 || mul_done_o !== 1'b0 || {hi, lo} !== 64'd0) begin
         errors++;
         $display("FAIL reset in busy: got stall=%b done=%b hi/lo=%h_%h expected 0 0 0_0",
                  stall_o, mul_done_o, hi, lo);
      end
      pulsed = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mul_done_o || stall_o) pulsed = 1'b1;
      end
      checks++;
      if (pulsed) begin
         errors++;
         $display("FAIL abandoned mult: got late done/stall activity expected none");
      end
   endtask

   task automatic test_reset_with_mul();
      @(posedge clk); #1;
      rst = 1'b1; valid = 1'b1; aluop = 2'b00; funct = 6'b011000; rs = 32'd9; rt = 32'd9;
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0 || mul_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset wins: got stall=%b done=%b expected 0 0", stall_o, mul_done_o);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mult_signed();
      test_multu();
      test_step4();
      test_back_to_back();
      test_hold_after_mult();
      test_reset_in_busy();
      test_reset_with_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
